// File: rtl/cdb_sender.sv
// Result buffer between one functional unit and the CDB: a circular FIFO of
// completed results offered to the CDB arbiter with a require/accept handshake.
module cdb_sender #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned LW    = 4
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     WEN,
  input  logic [DW-1:0]            dataIn,
  input  logic [LW-1:0]            labelIn,
  output logic                     available,
  output logic                     require,
  input  logic                     requireAC,
  output logic [DW-1:0]            dataOut,
  output logic [LW-1:0]            labelOut,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic [LW-1:0] label_out_q, label_out_d;

  logic [DW-1:0] data_mem_q  [DEPTH];
  logic [LW-1:0] label_mem_q [DEPTH];

  logic pop, push, push_req, full;

  // Handshake, pointer/count update and next head; head is precomputed so the
  // CDB-facing outputs come straight from flops.
  always_comb begin
    pop         = (state_q == SEND) & requireAC;
    full        = (count_q == CW'(DEPTH));
    push_req    = WEN & (labelIn != '0);
    push        = push_req & (~full | pop);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    wr_ptr_d    = wr_ptr_q + PW'(push);
    count_d     = count_q + CW'(push) - CW'(pop);
    overflow_d  = overflow_q | (push_req & full & ~pop);
    state_d     = state_q;
    data_out_d  = '0;
    label_out_d = '0;

    case (state_q)
      IDLE:    if (push) state_d = SEND;
      SEND:    if (pop && !push && count_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new head may be the entry being written on this same edge.
    if (state_d == SEND) begin
      if (push && rd_ptr_d == wr_ptr_q) begin
        data_out_d  = dataIn;
        label_out_d = labelIn;
      end else begin
        data_out_d  = data_mem_q[rd_ptr_d];
        label_out_d = label_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      data_out_q  <= '0;
      label_out_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      data_out_q  <= data_out_d;
      label_out_q <= label_out_d;
    end
  end

  // Entry storage is not reset; outputs are masked by state instead.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q]  <= dataIn;
      label_mem_q[wr_ptr_q] <= labelIn;
    end
  end

  assign require   = (state_q == SEND);
  assign dataOut   = data_out_q;
  assign labelOut  = label_out_q;
  assign count     = count_q;
  assign available = (count_q < CW'(DEPTH - 1)) | ((count_q == CW'(DEPTH - 1)) & ~WEN);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (nRST) assert (require == (count_q != '0));
  end
`endif

endmodule

// File: tb/tb_cdb_sender.sv
// Bench for cdb_sender: vector table with hand-derived counts, plus a
// scoreboard queue that predicts the head offered on the CDB each cycle.
module tb_cdb_sender;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          nRST;
  logic          WEN;
  logic [DW-1:0] dataIn;
  logic [LW-1:0] labelIn;
  logic          available;
  logic          require;
  logic          requireAC;
  logic [DW-1:0] dataOut;
  logic [LW-1:0] labelOut;
  logic [CW-1:0] count;

  cdb_sender #(.DEPTH(DEPTH), .DW(DW), .LW(LW)) dut (
    .clk(clk), .nRST(nRST), .WEN(WEN), .dataIn(dataIn), .labelIn(labelIn),
    .available(available), .require(require), .requireAC(requireAC),
    .dataOut(dataOut), .labelOut(labelOut), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [LW-1:0] label;
    logic [DW-1:0] data;
    logic          ac;
    int            exp_count;
    logic          exp_ovf;
  } vec_t;

  typedef struct {
    logic [LW-1:0] label;
    logic [DW-1:0] data;
  } ent_t;

  ent_t exp_q[$];
  vec_t vt[30];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs just before the edge, against the scoreboard contents.
  task automatic pre_check(input string tag, input logic wen);
    int n;
    n = exp_q.size();
    check({tag, "_count"}, 64'(count), 64'(n));
    check({tag, "_require"}, 64'(require), 64'(n != 0));
    check({tag, "_available"}, 64'(available),
          64'((n < int'(DEPTH) - 1) || (n == int'(DEPTH) - 1 && !wen)));
    if (n != 0) begin
      check({tag, "_labelOut"}, 64'(labelOut), 64'(exp_q[0].label));
      check({tag, "_dataOut"}, 64'(dataOut), 64'(exp_q[0].data));
    end else begin
      check({tag, "_labelOut"}, 64'(labelOut), 64'(0));
      check({tag, "_dataOut"}, 64'(dataOut), 64'(0));
    end
  endtask

  task automatic model_edge(input logic wen, input logic [LW-1:0] lbl,
                            input logic [DW-1:0] d, input logic ac);
    bit   pop;
    bit   full;
    ent_t e;
    pop  = (exp_q.size() != 0) && ac;
    full = (exp_q.size() == int'(DEPTH));
    if (pop) void'(exp_q.pop_front());
    if (wen && lbl != '0 && (!full || pop)) begin
      e.label = lbl;
      e.data  = d;
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input string tag, input logic wen, input logic [LW-1:0] lbl,
                       input logic [DW-1:0] d, input logic ac);
    WEN = wen; labelIn = lbl; dataIn = d; requireAC = ac;
    @(negedge clk);
    pre_check(tag, wen);
    model_edge(wen, lbl, d, ac);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        wen  label  data          ac  cnt ovf
    vt[0]  = '{1'b1, 4'd3,  32'h0000_00A5, 1'b1, 1, 1'b0};
    vt[1]  = '{1'b0, 4'd0,  32'h0,         1'b1, 0, 1'b0};
    vt[2]  = '{1'b0, 4'd0,  32'h0,         1'b0, 0, 1'b0};
    vt[3]  = '{1'b1, 4'd0,  32'hDEAD_BEEF, 1'b0, 0, 1'b0};
    vt[4]  = '{1'b0, 4'd0,  32'h0,         1'b1, 0, 1'b0};
    vt[5]  = '{1'b1, 4'd1,  32'h11,        1'b0, 1, 1'b0};
    vt[6]  = '{1'b1, 4'd2,  32'h22,        1'b0, 2, 1'b0};
    vt[7]  = '{1'b1, 4'd3,  32'h33,        1'b0, 3, 1'b0};
    vt[8]  = '{1'b1, 4'd4,  32'h44,        1'b0, 4, 1'b0};
    vt[9]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4, 1'b0};
    vt[10] = '{1'b0, 4'd0,  32'h0,         1'b1, 3, 1'b0};
    vt[11] = '{1'b0, 4'd0,  32'h0,         1'b1, 2, 1'b0};
    vt[12] = '{1'b0, 4'd0,  32'h0,         1'b1, 1, 1'b0};
    vt[13] = '{1'b0, 4'd0,  32'h0,         1'b1, 0, 1'b0};
    vt[14] = '{1'b0, 4'd0,  32'h0,         1'b0, 0, 1'b0};
    vt[15] = '{1'b1, 4'd1,  32'h101,       1'b0, 1, 1'b0};
    vt[16] = '{1'b1, 4'd2,  32'h102,       1'b0, 2, 1'b0};
    vt[17] = '{1'b1, 4'd3,  32'h103,       1'b0, 3, 1'b0};
    vt[18] = '{1'b1, 4'd4,  32'h104,       1'b0, 4, 1'b0};
    vt[19] = '{1'b1, 4'd5,  32'h105,       1'b1, 4, 1'b0};
    vt[20] = '{1'b1, 4'd6,  32'h106,       1'b0, 4, 1'b1};
    vt[21] = '{1'b0, 4'd0,  32'h0,         1'b1, 3, 1'b1};
    vt[22] = '{1'b0, 4'd0,  32'h0,         1'b1, 2, 1'b1};
    vt[23] = '{1'b0, 4'd0,  32'h0,         1'b1, 1, 1'b1};
    vt[24] = '{1'b0, 4'd0,  32'h0,         1'b1, 0, 1'b1};
    vt[25] = '{1'b0, 4'd0,  32'h0,         1'b0, 0, 1'b1};
    vt[26] = '{1'b1, 4'd8,  32'h108,       1'b1, 1, 1'b1};
    vt[27] = '{1'b1, 4'd9,  32'h109,       1'b1, 1, 1'b1};
    vt[28] = '{1'b1, 4'd10, 32'h10A,       1'b1, 1, 1'b1};
    vt[29] = '{1'b0, 4'd0,  32'h0,         1'b1, 0, 1'b1};

    nRST = 1'b0; WEN = 1'b0; labelIn = '0; dataIn = '0; requireAC = 1'b0;
    #2;
    check("rst_require", 64'(require), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_dataOut", 64'(dataOut), 64'(0));
    check("rst_labelOut", 64'(labelOut), 64'(0));
    check("rst_available", 64'(available), 64'(1));
    #10;
    nRST = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      drive($sformatf("vec%0d", i), vt[i].wen, vt[i].label, vt[i].data, vt[i].ac);
      check($sformatf("vec%0d_count_after", i), 64'(count), 64'(vt[i].exp_count));
      check($sformatf("vec%0d_overflow", i), 64'(dut.overflow_q), 64'(vt[i].exp_ovf));
    end

    // Reset asserted between edges while three results are held.
    drive("ar0", 1'b1, 4'd1, 32'h201, 1'b0);
    drive("ar1", 1'b1, 4'd2, 32'h202, 1'b0);
    drive("ar2", 1'b1, 4'd3, 32'h203, 1'b0);
    check("ar_count_held", 64'(count), 64'(3));
    WEN = 1'b0; requireAC = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    check("ar_require", 64'(require), 64'(0));
    check("ar_count", 64'(count), 64'(0));
    check("ar_dataOut", 64'(dataOut), 64'(0));
    check("ar_labelOut", 64'(labelOut), 64'(0));
    check("ar_available", 64'(available), 64'(1));
    check("ar_overflow", 64'(dut.overflow_q), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    check("ar_count_in_reset", 64'(count), 64'(0));
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    #1;
    drive("post0", 1'b1, 4'd7, 32'h777, 1'b1);
    drive("post1", 1'b0, 4'd0, 32'h0, 1'b1);
    check("post_count", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_sender.md
CDB_SENDER -- requirements
Module: cdb_sender

Sits between one functional unit (ALU, MUL, DIV or memory) and the CDB. It buffers completed results and presents them to CDBHelper/CDB with a require/accept handshake.

Interface
REQ-001 Parameter DEPTH, default 4, number of result entries (power of two, >= 2).
REQ-002 Parameter DW, default 32, result data width.
REQ-003 Parameter LW, default 4, tag (label) width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 nRST  input  1  reset, asynchronous and active-low.
REQ-006 WEN  input  1  functional unit presents a completed result this cycle.
REQ-007 dataIn  input  DW  result value.
REQ-008 labelIn  input  LW  tag of the producing reservation-station entry.
REQ-009 available  output  1  high when the unit may issue another result next cycle.
REQ-010 require  output  1  request for the CDB; feeds one bit of CDBHelper requires and the CDB sel vector.
REQ-011 requireAC  input  1  grant from CDBHelper for this sender.
REQ-012 dataOut  output  DW  head result value, driven to CDB dataN.
REQ-013 labelOut  output  LW  head tag, driven to CDB labelN.
REQ-014 count  output  log2(DEPTH)+1  number of entries held.

Function
REQ-015 Storage SHALL be a circular FIFO with read pointer, write pointer and count registers; pointers wrap modulo DEPTH.
REQ-016 Push SHALL occur at a rising edge when WEN=1, labelIn!=0 and the FIFO is not full, or when it is full but a pop occurs on the same edge.
REQ-017 A push with labelIn=0 SHALL be discarded without changing state, because tag 0 means "no producer".
REQ-018 Pop SHALL occur at a rising edge when require=1 and requireAC=1.
REQ-019 When a push and a pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 A push while full with no pop SHALL be dropped, and an internal sticky overflow flag SHALL be set.
REQ-020a The overflow flag SHALL be visible only to simulation assertions.
REQ-021 require SHALL equal (count!=0); it is registered state, not dependent on WEN in the same cycle.
REQ-022 Minimum latency from the push edge to require=1 SHALL be one cycle.
REQ-023 dataOut and labelOut SHALL show the head entry whenever require=1.
REQ-024 When require=0, dataOut and labelOut SHALL be 0, so that an unselected CDB input contributes a zero tag.
REQ-025 require SHALL remain asserted, and the head entry SHALL remain stable, until the cycle in which requireAC=1; no retraction is allowed.
REQ-026 requireAC=1 while require=0 SHALL be ignored.
REQ-027 available SHALL be (count < DEPTH-1) | ((count == DEPTH-1) & ~WEN), i.e. registered-count based and conservative by one entry.
REQ-027a As a result of REQ-027, a unit honouring available never overflows the FIFO.
REQ-028 Ordering SHALL be strict FIFO; results leave in push order regardless of tag value.
REQ-029 Throughput SHALL be one push and one pop per cycle sustained.
REQ-030 Two-state control view: IDLE (count=0, require=0) and SEND (count>0, require=1).
REQ-030a IDLE->SEND on a push.
REQ-030b SEND->IDLE on a pop with count=1 and no simultaneous push.
REQ-030c Otherwise the current state holds.

Reset
REQ-031 While nRST=0, the block SHALL immediately clear the pointers, count and overflow flag.
REQ-031a While nRST=0: require=0, dataOut=0, labelOut=0, available=1.
REQ-032 Entry storage need not be cleared; outputs SHALL still read 0 because of REQ-024.
REQ-033 Reset asserted mid-transfer SHALL discard all held results.
REQ-033a After reset releases, the first edge SHALL behave as from IDLE.

Verification
REQ-034 Single result: push data=0x0000_00A5, label=3 with requireAC held 1 -> require=1 one cycle later with labelOut=3 and dataOut=0xA5; require=0 on the following cycle.
REQ-035 Back-pressure: push labels 1,2,3,4 with requireAC=0 -> count=4 and available=0; then requireAC=1 for 4 cycles -> labels 1,2,3,4 appear in order and require falls after the 4th grant.
REQ-036 Full with simultaneous push/pop: count=4, push label 5 together with a grant -> label 1 leaves, count stays 4, order becomes 2,3,4,5, and the overflow flag stays clear.
REQ-037 Overflow: count=4, push label 6 with no grant -> entry dropped, count=4, overflow flag=1, and the subsequent drain yields 2,3,4,5 (or the prior contents).
REQ-038 Discard and spurious grant: push labelIn=0 -> count stays 0 and require stays 0; requireAC=1 while empty -> no state change.
REQ-039 Asynchronous reset: with count=3, drop nRST between clock edges -> require, count, dataOut and labelOut read 0 before the next edge; after release, push label 7 -> label 7 is the first result out.
